mux_nxw_rr: RTL and testbench
=============================

Name: mux_nxw_rr

Overview:
Parametrised N-input, W-bit registered multiplexer. It is the successor to the fixed 2x16 combinational mux. Each input channel has a valid/ready handshake, and the block drives one registered output with its own valid/ready handshake. Channel selection is either explicit (sel_in) or round-robin arbitration, chosen at run time by mode_in. It sits in the datapath wherever several producers share one consumer, e.g. writeback/result-bus merging.

Parameters:
N, 4, number of input channels (2..16)
W, 16, data width in bits
SELW, $clog2(N), width of select/grant fields (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset; one clock; synchronous, active-low
mode_in  input  1  0 = explicit select, 1 = round-robin
sel_in  input  SELW  channel index used when mode_in=0
valid_in  input  N  per-channel data valid
d_in  input  N*W  packed channel data; channel i = d_in[i*W +: W]
ready_out  output  N  per-channel accept (combinational)
m_out  output  W  registered output data
valid_out  output  1  m_out holds valid data
ready_in  input  1  consumer accepts m_out this cycle
grant_out  output  SELW  registered index of the channel that produced m_out

Behaviour:
- Reset (rst_n=0 at a rising edge): valid_out=0, m_out=0, grant_out=0, round-robin pointer=N-1, so channel 0 has first priority after reset. ready_out is all 0 while rst_n=0.
- Output register is single-entry. Define can_load = !valid_out || ready_in.
- Transfer on channel i: valid_in[i] && ready_out[i] at a rising edge. At most one ready_out bit is high per cycle (one-hot or zero).
- Explicit mode (mode_in=0):
  - ready_out[sel_in] = can_load && valid_in[sel_in].
  - If sel_in >= N, no channel is accepted and ready_out is all 0.
  - The round-robin pointer is not updated in this mode.
- Round-robin mode (mode_in=1):
  - Search valid_in starting at ptr+1 and wrapping modulo N; the first valid channel wins.
  - ready_out[winner] = can_load.
  - On a transfer, ptr <= winner. With no transfer, ptr holds.
- On a transfer: m_out <= d_in[winner], grant_out <= winner, valid_out <= 1. Latency is 1 cycle from input transfer to valid_out.
- If valid_out && ready_in and there is no transfer, valid_out <= 0. m_out and grant_out keep their last values.
- Back-pressure: while valid_out && !ready_in, m_out, grant_out and valid_out stay stable and ready_out is all 0.
- Simultaneous drain and load (valid_out && ready_in plus a new transfer): the new data replaces the old in the same edge and valid_out stays 1. Full throughput is one word per cycle.
- Changing mode_in or sel_in never affects the held output word. The new mode/select applies from the current cycle's combinational selection.
- Reset asserted mid-operation: the pending output is discarded (valid_out=0) and ptr returns to N-1 on that edge.
- Inputs are not required to hold valid_in once it is asserted. An unaccepted word may be withdrawn without error.
- No combinational path from ready_in to m_out or valid_out. The ready_in -> ready_out combinational path is permitted.

Test Plan:
1. Explicit select, N=4, W=16: sel_in=2, valid_in=4'b0100, d_in ch2=16'hBEEF, ready_in=1 -> ready_out=4'b0100 that cycle; next cycle valid_out=1, m_out=16'hBEEF, grant_out=2.
2. Round-robin fairness: mode_in=1, valid_in=4'b1111 held, ch i data=16'h1000+i, ready_in=1 from reset -> grant_out sequence 0,1,2,3,0,… and m_out 16'h1000,16'h1001,16'h1002,16'h1003,16'h1000, one word per cycle.
3. Back-pressure: load 16'hA5A5, hold ready_in=0 for 5 cycles with valid_in=4'b1111 -> m_out=16'hA5A5 and valid_out=1 stable, ready_out=0 throughout. Raise ready_in -> next word loads on the same edge.
4. Round-robin skip and wrap: mode_in=1, ptr=2 (ch2 last granted), valid_in=4'b0011 -> ch0 granted, not ch1. Next cycle with the same inputs -> ch1 granted.
5. Out-of-range select, N=3 (SELW=2): sel_in=3, valid_in=3'b111 -> ready_out=0, valid_out stays 0.
6. Reset mid-operation: valid_out=1 with m_out=16'h1234, rst_n=0 for one edge -> valid_out=0, m_out=0, grant_out=0. With mode_in=1 and valid_in all 1 after release, the first grant is ch0.

Source files
------------

// File: rtl/mux_nxw_rr.sv
// mux_nxw_rr: N-input W-bit registered mux, explicit select or round-robin, valid/ready on both sides
module mux_nxw_rr #(
    parameter int N = 4,
    parameter int W = 16,
    localparam int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_in,
    input  logic [SELW-1:0]   sel_in,
    input  logic [N-1:0]      valid_in,
    input  logic [N*W-1:0]    d_in,
    output logic [N-1:0]      ready_out,
    output logic [W-1:0]      m_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [SELW-1:0]   grant_out
);
    logic [W-1:0]    m_q, m_d;
    logic            valid_q, valid_d;
    logic [SELW-1:0] grant_q, grant_d, ptr_q, ptr_d, win;
    logic            found, can_load, xfer;
    always_comb begin
        can_load = !valid_q || ready_in;
        found = 1'b0;
        win = '0;
        if (mode_in) begin
            // first valid channel after the last granted one, wrapping
            for (int k = 1; k <= N; k++) begin
                if (!found && valid_in[(int'(ptr_q) + k) % N]) begin
                    found = 1'b1;
                    win = SELW'((int'(ptr_q) + k) % N);
                end
            end
        end else if (int'(sel_in) < N) begin
            found = valid_in[int'(sel_in)];
            win = sel_in;
        end
        ready_out = '0;
        if (rst_n && found && can_load) ready_out[win] = 1'b1;
        xfer = |ready_out;
        m_d = xfer ? d_in[int'(win)*W +: W] : m_q;
        grant_d = xfer ? win : grant_q;
        valid_d = xfer || (valid_q && !ready_in);
        ptr_d = (xfer && mode_in) ? win : ptr_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_q <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            ptr_q <= SELW'(N - 1);
        end else begin
            m_q <= m_d;
            valid_q <= valid_d;
            grant_q <= grant_d;
            ptr_q <= ptr_d;
        end
    end
    assign m_out = m_q;
    assign valid_out = valid_q;
    assign grant_out = grant_q;
endmodule

// File: tb/tb_mux_nxw_rr.sv
// tb_mux_nxw_rr: directed checks of mux_nxw_rr (N=4 main instance, N=3 for out-of-range select)
module tb_mux_nxw_rr;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode, rdy, valid_out, mode_b, rdy_b, valid_out_b;
    logic [1:0]  sel, grant, sel_b, grant_b;
    logic [3:0]  valid, ready_out;
    logic [2:0]  valid_b, ready_out_b;
    logic [63:0] d;
    logic [47:0] d_b;
    logic [15:0] m, m_b;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_nxw_rr #(.N(4), .W(16)) dut (
        .clk(clk), .rst_n(rst_n), .mode_in(mode), .sel_in(sel), .valid_in(valid),
        .d_in(d), .ready_out(ready_out), .m_out(m), .valid_out(valid_out),
        .ready_in(rdy), .grant_out(grant)
    );

    mux_nxw_rr #(.N(3), .W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode_in(mode_b), .sel_in(sel_b), .valid_in(valid_b),
        .d_in(d_b), .ready_out(ready_out_b), .m_out(m_b), .valid_out(valid_out_b),
        .ready_in(rdy_b), .grant_out(grant_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic seq_data;
        for (int i = 0; i < 4; i++) d[i*16 +: 16] = 16'h1000 + 16'(i);
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b1; sel = 2'd0; valid = 4'b1111; rdy = 1'b1; seq_data();
        mode_b = 1'b0; sel_b = 2'd3; valid_b = 3'b111; d_b = {16'h3333, 16'h2222, 16'h1111}; rdy_b = 1'b1;
        tick(); tick();
        check("rst_ready", 32'(ready_out), 32'h0);
        check("rst_valid", 32'(valid_out), 32'h0);
        check("rst_m", 32'(m), 32'h0);
        check("rst_grant", 32'(grant), 32'h0);

        // explicit select ch2
        rst_n = 1'b1; mode = 1'b0; sel = 2'd2; valid = 4'b0100; d[32 +: 16] = 16'hBEEF;
        #1 check("sel_ready", 32'(ready_out), 32'h4);
        check("oor_ready_b", 32'(ready_out_b), 32'h0);
        tick();
        check("sel_valid", 32'(valid_out), 32'h1);
        check("sel_m", 32'(m), 32'hBEEF);
        check("sel_grant", 32'(grant), 32'h2);
        check("oor_valid_b", 32'(valid_out_b), 32'h0);
        valid = 4'b0000;
        tick();
        check("drain_valid", 32'(valid_out), 32'h0);
        check("drain_m_hold", 32'(m), 32'hBEEF);
        check("oor_valid_b2", 32'(valid_out_b), 32'h0);

        // round-robin fairness from reset
        rst_n = 1'b0; mode = 1'b1; valid = 4'b1111; seq_data();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_grant", 32'(grant), 32'(i % 4));
            check("rr_m", 32'(m), 32'h1000 + 32'(i % 4));
            check("rr_valid", 32'(valid_out), 32'h1);
        end

        // back-pressure: ch1 loads A5A5, then consumer stalls
        d = {4{16'hA5A5}};
        tick();
        rdy = 1'b0; seq_data();
        for (int i = 0; i < 5; i++) begin
            #1 check("bp_ready", 32'(ready_out), 32'h0);
            tick();
            check("bp_m", 32'(m), 32'hA5A5);
            check("bp_valid", 32'(valid_out), 32'h1);
            check("bp_grant", 32'(grant), 32'h1);
        end
        rdy = 1'b1;
        #1 check("bp_release_ready", 32'(ready_out), 32'h4);
        tick();
        check("bp_release_m", 32'(m), 32'h1002);
        check("bp_release_grant", 32'(grant), 32'h2);

        // skip and wrap with ptr=2
        valid = 4'b0011;
        #1 check("wrap_ready0", 32'(ready_out), 32'h1);
        tick();
        check("wrap_grant0", 32'(grant), 32'h0);
        check("wrap_m0", 32'(m), 32'h1000);
        #1 check("wrap_ready1", 32'(ready_out), 32'h2);
        tick();
        check("wrap_grant1", 32'(grant), 32'h1);
        check("wrap_m1", 32'(m), 32'h1001);

        // reset mid-operation; explicit mode leaves ptr at 1 beforehand
        mode = 1'b0; sel = 2'd0; valid = 4'b0001; d[0 +: 16] = 16'h1234;
        tick();
        check("mid_m", 32'(m), 32'h1234);
        check("mid_valid", 32'(valid_out), 32'h1);
        rdy = 1'b0; rst_n = 1'b0;
        tick();
        check("mid_rst_valid", 32'(valid_out), 32'h0);
        check("mid_rst_m", 32'(m), 32'h0);
        check("mid_rst_grant", 32'(grant), 32'h0);
        rst_n = 1'b1; mode = 1'b1; valid = 4'b1111; rdy = 1'b1; seq_data();
        #1 check("post_rst_ready", 32'(ready_out), 32'h1);
        tick();
        check("post_rst_grant", 32'(grant), 32'h0);
        check("post_rst_m", 32'(m), 32'h1000);
        check("post_rst_valid", 32'(valid_out), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
